// File: rtl/controller_m_stage_if.sv
// controller_m_stage_if: bus bundle between the pipeline and the M-stage
// memory controller. The controller sits on the slave modport; whoever
// drives the pipeline inputs and observes the decoded controls uses master.
interface controller_m_stage_if;
    // Pipeline control
    logic        Stall;
    logic        Flush;
    // Data coming down from the execute stage
    logic [31:0] Instr_E;
    logic [31:0] ALUOutput_M;
    logic [31:0] RTV_M;
    logic [31:0] MUXRFWDOut;
    logic        ForwardRTM;
    // Decoded memory-stage controls
    logic [31:0] Instr_M;
    logic [1:0]  StoreSel;
    logic        MemWrite;
    logic        MemRead;
    logic [2:0]  LoadSel;
    logic [3:0]  BE;
    logic [31:0] MFRTMOut;
    logic        AddrExc;

    modport slave (
        input  Stall, Flush, Instr_E, ALUOutput_M, RTV_M, MUXRFWDOut, ForwardRTM,
        output Instr_M, StoreSel, MemWrite, MemRead, LoadSel, BE, MFRTMOut, AddrExc
    );

    modport master (
        output Stall, Flush, Instr_E, ALUOutput_M, RTV_M, MUXRFWDOut, ForwardRTM,
        input  Instr_M, StoreSel, MemWrite, MemRead, LoadSel, BE, MFRTMOut, AddrExc
    );
endinterface

// File: rtl/controller_m_stage.sv
// controller_m_stage: memory-stage pipeline register plus load/store decode.
// Instr_M is the only state; every other output is decoded combinationally
// from Instr_M, the effective address and the store-data forwarding mux.
// Optional feature: define MISALIGN_CHECK_EN to flag misaligned word/half
// accesses on AddrExc and suppress the write of a misaligned store.
module controller_m_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic                  CLK,
    input  logic                  Reset,
    controller_m_stage_if.slave   bus
);

    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;

    // A word access must sit on a 4-byte boundary.
    function automatic logic word_misaligned(input logic [1:0] low_bits);
        return (low_bits != 2'b00);
    endfunction

    // A halfword access must sit on a 2-byte boundary.
    function automatic logic half_misaligned(input logic [1:0] low_bits);
        return low_bits[0];
    endfunction

    logic [31:0] instr_r;
    logic [5:0]  opcode_s;
    logic [1:0]  addr_lo_s;
    logic        is_store_s;
    logic        misalign_s;
    logic [3:0]  be_raw_s;
    logic [1:0]  store_sel_s;
    logic [2:0]  load_sel_s;
    logic        mem_read_s;
    logic        unused_addr_s;

    assign opcode_s      = instr_r[31:26];
    assign addr_lo_s     = bus.ALUOutput_M[1:0];
    assign unused_addr_s = ^bus.ALUOutput_M[31:2];

    // M-stage instruction register: reset and flush insert a bubble, stall holds.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            instr_r <= NOP_INSTR;
        end else if (bus.Flush) begin
            instr_r <= NOP_INSTR;
        end else if (bus.Stall) begin
            instr_r <= instr_r;
        end else begin
            instr_r <= bus.Instr_E;
        end
    end

    // Opcode decode into store/load controls and raw byte enables.
    always_comb begin
        is_store_s  = 1'b0;
        misalign_s  = 1'b0;
        be_raw_s    = 4'b0000;
        store_sel_s = 2'b00;
        load_sel_s  = 3'b000;
        mem_read_s  = 1'b0;
        case (opcode_s)
            OP_SW: begin
                is_store_s = 1'b1;
                be_raw_s   = 4'b1111;
                misalign_s = word_misaligned(addr_lo_s);
            end
            OP_SB: begin
                is_store_s  = 1'b1;
                store_sel_s = 2'b01;
                be_raw_s    = 4'b0001 << addr_lo_s;
            end
            OP_SH: begin
                is_store_s  = 1'b1;
                store_sel_s = 2'b10;
                if (addr_lo_s[1]) begin
                    be_raw_s = 4'b1100;
                end else begin
                    be_raw_s = 4'b0011;
                end
                misalign_s = half_misaligned(addr_lo_s);
            end
            OP_LW: begin
                mem_read_s = 1'b1;
                load_sel_s = 3'b000;
                misalign_s = word_misaligned(addr_lo_s);
            end
            OP_LB: begin
                mem_read_s = 1'b1;
                load_sel_s = 3'b001;
            end
            OP_LBU: begin
                mem_read_s = 1'b1;
                load_sel_s = 3'b010;
            end
            OP_LH: begin
                mem_read_s = 1'b1;
                load_sel_s = 3'b011;
                misalign_s = half_misaligned(addr_lo_s);
            end
            OP_LHU: begin
                mem_read_s = 1'b1;
                load_sel_s = 3'b100;
                misalign_s = half_misaligned(addr_lo_s);
            end
            default: begin
                is_store_s = 1'b0;
            end
        endcase
    end

    assign bus.Instr_M  = instr_r;
    assign bus.StoreSel = store_sel_s;
    assign bus.MemRead  = mem_read_s;
    assign bus.LoadSel  = load_sel_s;

    // Store data: forwarded writeback value or the rt value from the pipe.
    assign bus.MFRTMOut = bus.ForwardRTM ? bus.MUXRFWDOut : bus.RTV_M;

`ifdef MISALIGN_CHECK_EN
    // A misaligned store must never reach memory.
    assign bus.AddrExc  = misalign_s;
    assign bus.MemWrite = is_store_s & ~misalign_s;
    assign bus.BE       = misalign_s ? 4'b0000 : be_raw_s;
`else
    logic unused_misalign_s;
    assign unused_misalign_s = misalign_s;
    assign bus.AddrExc  = 1'b0;
    assign bus.MemWrite = is_store_s;
    assign bus.BE       = be_raw_s;
`endif

endmodule

// File: tb/tb_controller_m_stage.sv
// tb_controller_m_stage: table-driven check of the M-stage decode plus
// hand-written sequences for reset, stall, flush and forwarding.
module tb_controller_m_stage;

    logic CLK;
    logic Reset;
    int   n_checks;
    int   n_fail;

    controller_m_stage_if bus ();

    controller_m_stage #(.NOP_INSTR(32'h0000_0000)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

`ifdef MISALIGN_CHECK_EN
    localparam logic MIS = 1'b1;
`else
    localparam logic MIS = 1'b0;
`endif

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
        logic [31:0] rtv;
        logic [31:0] fwd_data;
        logic        fwd_sel;
        logic        mw;
        logic        mr;
        logic [1:0]  ss;
        logic [2:0]  ls;
        logic [3:0]  be;
        logic        ae;
        logic [31:0] mfrtm;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] addr,
                                input logic [31:0] rtv, input logic [31:0] fwd_data,
                                input logic fwd_sel, input logic mw, input logic mr,
                                input logic [1:0] ss, input logic [2:0] ls,
                                input logic [3:0] be, input logic ae,
                                input logic [31:0] mfrtm);
        vec_t v;
        v.instr = instr; v.addr = addr; v.rtv = rtv; v.fwd_data = fwd_data;
        v.fwd_sel = fwd_sel; v.mw = mw; v.mr = mr; v.ss = ss; v.ls = ls;
        v.be = be; v.ae = ae; v.mfrtm = mfrtm;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        Reset           = 1'b1;
        bus.Stall       = 1'b0;
        bus.Flush       = 1'b0;
        bus.Instr_E     = 32'hAC08_0004;
        bus.ALUOutput_M = 32'h0000_0000;
        bus.RTV_M       = 32'h1111_1111;
        bus.MUXRFWDOut  = 32'h2222_2222;
        bus.ForwardRTM  = 1'b0;

        //            instr         addr          rtv           fwd           sel  mw    mr    ss     ls      be       ae    mfrtm
        vecs[0]  = mk(32'hAC08_0004, 32'h0000_1000, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 4'b1111, 1'b0, 32'h1111_1111);
        vecs[1]  = mk(32'hA000_0000, 32'h0000_0010, 32'h1111_1111, 32'h2222_2222, 1'b1, 1'b1, 1'b0, 2'b01, 3'b000, 4'b0001, 1'b0, 32'h2222_2222);
        vecs[2]  = mk(32'hA000_0000, 32'h0000_0011, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 1'b1, 1'b0, 2'b01, 3'b000, 4'b0010, 1'b0, 32'hDEAD_BEEF);
        vecs[3]  = mk(32'hA000_0000, 32'h0000_0012, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b1, 1'b0, 2'b01, 3'b000, 4'b0100, 1'b0, 32'h0BAD_F00D);
        vecs[4]  = mk(32'hA000_0000, 32'h0000_0013, 32'h0000_00FF, 32'hFF00_0000, 1'b0, 1'b1, 1'b0, 2'b01, 3'b000, 4'b1000, 1'b0, 32'h0000_00FF);
        vecs[5]  = mk(32'hA400_0000, 32'h0000_0020, 32'h1234_5678, 32'h8765_4321, 1'b1, 1'b1, 1'b0, 2'b10, 3'b000, 4'b0011, 1'b0, 32'h8765_4321);
        vecs[6]  = mk(32'hA400_0000, 32'h0000_0022, 32'h1234_5678, 32'h8765_4321, 1'b0, 1'b1, 1'b0, 2'b10, 3'b000, 4'b1100, 1'b0, 32'h1234_5678);
        vecs[7]  = mk(32'hA400_0000, 32'h0000_0003, 32'h1234_5678, 32'h8765_4321, 1'b0, !MIS, 1'b0, 2'b10, 3'b000, MIS ? 4'b0000 : 4'b1100, MIS, 32'h1234_5678);
        vecs[8]  = mk(32'h8C09_0008, 32'h0000_0040, 32'hAAAA_5555, 32'h5555_AAAA, 1'b1, 1'b0, 1'b1, 2'b00, 3'b000, 4'b0000, 1'b0, 32'h5555_AAAA);
        vecs[9]  = mk(32'h8000_0000, 32'h0000_0041, 32'hAAAA_5555, 32'h5555_AAAA, 1'b0, 1'b0, 1'b1, 2'b00, 3'b001, 4'b0000, 1'b0, 32'hAAAA_5555);
        vecs[10] = mk(32'h9000_0000, 32'h0000_0043, 32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, 1'b1, 2'b00, 3'b010, 4'b0000, 1'b0, 32'h0000_0002);
        vecs[11] = mk(32'h8400_0000, 32'h0000_0046, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 1'b1, 2'b00, 3'b011, 4'b0000, 1'b0, 32'h0000_0001);
        vecs[12] = mk(32'h9400_0000, 32'h0000_0048, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 2'b00, 3'b100, 4'b0000, 1'b0, 32'h0000_0000);
        vecs[13] = mk(32'h8C09_0008, 32'h0000_0042, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 2'b00, 3'b000, 4'b0000, MIS, 32'hFFFF_FFFF);
        vecs[14] = mk(32'h2108_0001, 32'h0000_0003, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 4'b0000, 1'b0, 32'h1111_1111);
        vecs[15] = mk(32'h0000_0000, 32'h0000_0001, 32'h1111_1111, 32'h2222_2222, 1'b1, 1'b0, 1'b0, 2'b00, 3'b000, 4'b0000, 1'b0, 32'h2222_2222);
        vecs[16] = mk(32'hAC08_0004, 32'h0000_0101, 32'hCAFE_0000, 32'h0000_CAFE, 1'b0, !MIS, 1'b0, 2'b00, 3'b000, MIS ? 4'b0000 : 4'b1111, MIS, 32'hCAFE_0000);
        vecs[17] = mk(32'h9400_0000, 32'h0000_0005, 32'hCAFE_0000, 32'h0000_CAFE, 1'b1, 1'b0, 1'b1, 2'b00, 3'b100, 4'b0000, MIS, 32'h0000_CAFE);

        // Reset then a sw enters M one edge after reset is released.
        tick();
        check("rst_instr_m", bus.Instr_M, 32'h0000_0000);
        check("rst_memwrite", 32'(bus.MemWrite), 32'h0);
        check("rst_memread", 32'(bus.MemRead), 32'h0);
        check("rst_be", 32'(bus.BE), 32'h0);
        check("rst_storesel", 32'(bus.StoreSel), 32'h0);
        check("rst_loadsel", 32'(bus.LoadSel), 32'h0);
        check("rst_addrexc", 32'(bus.AddrExc), 32'h0);
        Reset = 1'b0;
        tick();
        check("sw_instr_m", bus.Instr_M, 32'hAC08_0004);
        check("sw_memwrite", 32'(bus.MemWrite), 32'h1);
        check("sw_storesel", 32'(bus.StoreSel), 32'h0);
        check("sw_be", 32'(bus.BE), 32'hF);

        // Table of single-instruction decode vectors.
        for (int i = 0; i < NV; i++) begin
            bus.Instr_E = vecs[i].instr;
            tick();
            bus.ALUOutput_M = vecs[i].addr;
            bus.RTV_M       = vecs[i].rtv;
            bus.MUXRFWDOut  = vecs[i].fwd_data;
            bus.ForwardRTM  = vecs[i].fwd_sel;
            #1;
            check($sformatf("v%0d_instr_m", i), bus.Instr_M, vecs[i].instr);
            check($sformatf("v%0d_memwrite", i), 32'(bus.MemWrite), 32'(vecs[i].mw));
            check($sformatf("v%0d_memread", i), 32'(bus.MemRead), 32'(vecs[i].mr));
            check($sformatf("v%0d_storesel", i), 32'(bus.StoreSel), 32'(vecs[i].ss));
            check($sformatf("v%0d_loadsel", i), 32'(bus.LoadSel), 32'(vecs[i].ls));
            check($sformatf("v%0d_be", i), 32'(bus.BE), 32'(vecs[i].be));
            check($sformatf("v%0d_addrexc", i), 32'(bus.AddrExc), 32'(vecs[i].ae));
            check($sformatf("v%0d_mfrtm", i), bus.MFRTMOut, vecs[i].mfrtm);
        end

        // Stall holds a sw for two edges while lw waits in E.
        bus.ALUOutput_M = 32'h0000_0000;
        bus.Instr_E = 32'hAC08_0004;
        tick();
        bus.Stall   = 1'b1;
        bus.Instr_E = 32'h8C09_0008;
        tick();
        check("stall1_instr_m", bus.Instr_M, 32'hAC08_0004);
        tick();
        check("stall2_instr_m", bus.Instr_M, 32'hAC08_0004);
        check("stall2_memwrite", 32'(bus.MemWrite), 32'h1);
        // Flush wins over stall.
        bus.Flush = 1'b1;
        tick();
        check("stallflush_instr_m", bus.Instr_M, 32'h0000_0000);
        check("stallflush_memwrite", 32'(bus.MemWrite), 32'h0);
        bus.Stall = 1'b0;
        bus.Flush = 1'b0;
        tick();
        check("release_instr_m", bus.Instr_M, 32'h8C09_0008);
        // Flush alone.
        bus.Flush = 1'b1;
        tick();
        check("flush_instr_m", bus.Instr_M, 32'h0000_0000);
        check("flush_memread", 32'(bus.MemRead), 32'h0);
        bus.Flush = 1'b0;

        // Reset while a store occupies M; data mux unaffected by reset.
        bus.Instr_E = 32'hA400_0000;
        tick();
        check("sh_before_rst_memwrite", 32'(bus.MemWrite), 32'h1);
        Reset = 1'b1;
        bus.RTV_M      = 32'h1111_1111;
        bus.MUXRFWDOut = 32'h2222_2222;
        bus.ForwardRTM = 1'b1;
        tick();
        check("rst_store_instr_m", bus.Instr_M, 32'h0000_0000);
        check("rst_store_memwrite", 32'(bus.MemWrite), 32'h0);
        check("rst_store_be", 32'(bus.BE), 32'h0);
        check("rst_mux_fwd1", bus.MFRTMOut, 32'h2222_2222);
        bus.ForwardRTM = 1'b0;
        #1;
        check("rst_mux_fwd0", bus.MFRTMOut, 32'h1111_1111);
        Reset = 1'b0;
        tick();
        check("after_rst_instr_m", bus.Instr_M, 32'hA400_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/controller_m_stage.md
CONTROLLER_M_STAGE -- requirements
Module: controller_m_stage

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high, with ports named CLK and Reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0000, SHALL be the instruction word loaded on reset or flush.
REQ-003 CLK  input  1  rising-edge clock.
REQ-004 Reset  input  1  synchronous active-high reset.
REQ-005 Stall  input  1  hold Instr_M.
REQ-006 Flush  input  1  replace Instr_M with NOP_INSTR.
REQ-007 Instr_E  input  32  instruction leaving the execute stage.
REQ-008 ALUOutput_M  input  32  memory byte address for the current M-stage instruction.
REQ-009 RTV_M  input  32  rt value carried down the pipeline.
REQ-010 MUXRFWDOut  input  32  writeback-stage forwarded data.
REQ-011 ForwardRTM  input  1  rt forward select.
REQ-012 Instr_M  output  32  registered M-stage instruction.
REQ-013 StoreSel  output  2  store width: 00 sw, 01 sb, 10 sh.
REQ-014 MemWrite  output  1  data-memory write enable.
REQ-015 MemRead  output  1  load instruction in M.
REQ-016 LoadSel  output  3  load type: 000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu.
REQ-017 BE  output  4  byte enables of the store.
REQ-018 MFRTMOut  output  32  forwarded store data.
REQ-019 AddrExc  output  1  misaligned access flag.

Function
REQ-020 Instr_M SHALL update on the rising edge of CLK with priority Reset, then Flush (both load NOP_INSTR), then Stall (hold), else Instr_E; latency is one cycle.
REQ-021 All outputs other than Instr_M SHALL be combinational from Instr_M, ALUOutput_M, RTV_M, MUXRFWDOut and ForwardRTM.
REQ-022 Decode SHALL use opcode Instr_M[31:26]: sw 101011, sb 101000, sh 101001, lw 100011, lb 100000, lbu 100100, lh 100001, lhu 100101.
REQ-023 MemWrite SHALL be 1 only for sw, sb and sh; StoreSel SHALL be 00 for sw and for every non-store.
REQ-024 MemRead SHALL be 1 only for the five loads; LoadSel SHALL be 000 for non-loads.
REQ-025 BE SHALL be 1111 for sw; 0011 for sh when ALUOutput_M[1]=0, else 1100; 0001 shifted left by ALUOutput_M[1:0] for sb; 0000 for non-stores.
REQ-026 MFRTMOut SHALL equal MUXRFWDOut when ForwardRTM=1, else RTV_M, a pure 32-bit 2:1 mux.
REQ-027 Unknown opcodes, including NOP_INSTR, SHALL produce MemWrite=0, MemRead=0, BE=0000 and AddrExc=0.
REQ-028 When Stall and Flush are asserted together, Flush SHALL win.

Reset
REQ-029 After a Reset edge, Instr_M SHALL be NOP_INSTR, so MemWrite=0, MemRead=0, StoreSel=00, LoadSel=000, BE=0000 and AddrExc=0.
REQ-030 Reset asserted while a store occupies M SHALL remove that store from the next cycle onward; reset SHALL have no effect on the data path of REQ-026.

Configuration
REQ-031 When macro MISALIGN_CHECK_EN is defined, AddrExc SHALL be 1 for:
- sw, lw with ALUOutput_M[1:0]!=00;
- sh, lh, lhu with ALUOutput_M[0]=1.
REQ-032 When MISALIGN_CHECK_EN is defined, a misaligned store SHALL force MemWrite=0 and BE=0000.
REQ-033 Without MISALIGN_CHECK_EN, AddrExc SHALL be tied to 0, and the byte-enable and write behaviour SHALL follow REQ-023 and REQ-025 regardless of address low bits.

Verification
REQ-034 Reset=1 for one edge, then Instr_E=32'hAC08_0004 (sw) with Reset=0 -> after the first edge Instr_M=0 and MemWrite=0; after the second edge Instr_M=32'hAC08_0004, MemWrite=1, StoreSel=00, BE=1111.
REQ-035 Instr_M=sb (opcode 101000) with ALUOutput_M[1:0]=00/01/10/11 -> BE=0001/0010/0100/1000, StoreSel=01, MemWrite=1.
REQ-036 RTV_M=32'h1111_1111, MUXRFWDOut=32'h2222_2222 -> ForwardRTM=0 gives MFRTMOut=32'h1111_1111; ForwardRTM=1 gives 32'h2222_2222.
REQ-037 Instr_M=sw, then Stall=1 for two edges with Instr_E=lw -> Instr_M is unchanged; then Stall=1 and Flush=1 together -> Instr_M=0 after the next edge.
REQ-038 With MISALIGN_CHECK_EN defined, sh with ALUOutput_M=32'h0000_0003 -> AddrExc=1, MemWrite=0, BE=0000; without the macro the same stimulus gives AddrExc=0, MemWrite=1, BE=1100.
REQ-039 Instr_M=lhu (opcode 100101) -> MemRead=1, LoadSel=100, MemWrite=0, BE=0000.
